tdc_48steps_decoder: RTL and testbench
======================================

TDC_48STEPS_DECODER -- requirements
Module: tdc_48steps_decoder

Interface
REQ-001 The block SHALL have parameter AVG_LOG2, default 2, which sets log2 of the number of samples averaged per measurement (legal range 0..4).
REQ-002 The block SHALL have input i_Clk_Ref, 1 bit: the single clock, rising-edge active, the same reference clock that samples the delay line.
REQ-003 The block SHALL have input i_RST_n, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have input i_TDC_code, 48 bits: raw delay-line capture word, with alternating polarity per stage.
REQ-005 The block SHALL have input i_Start, 1 bit: single-cycle request to begin a measurement.
REQ-006 The block SHALL have output o_Busy, 1 bit: high whenever the state is not IDLE.
REQ-007 The block SHALL have output o_Code, 6 bits: free-running decoded single-sample edge position, 0..48.
REQ-008 The block SHALL have output o_Sum, 6+AVG_LOG2 bits: accumulated sum of the last measurement.
REQ-009 The block SHALL have output o_Avg, 6 bits: o_Sum >> AVG_LOG2, truncated.
REQ-010 The block SHALL have output o_Valid, 1 bit: one-cycle pulse when o_Sum/o_Avg update.
REQ-011 The block SHALL have output o_Overflow, 1 bit: sticky flag, set when any accumulated sample had code 48.
REQ-012 The block SHALL have output o_Error, 1 bit: sticky flag, set when any accumulated sample was non-thermometer after filtering.

Function
REQ-013 Stage 1 SHALL register i_TDC_code unmodified every cycle, as a capture/metastability stage.
REQ-014 Stage 2 SHALL normalise n = s1 XOR 48'h5555_5555_5555, so that bit k=1 means the edge has passed cell k.
REQ-015 Stage 2 SHALL apply a 3-input majority filter per bit, f[k] = maj(n[k-1], n[k], n[k+1]), with virtual n[-1]=1 and n[48]=0; f SHALL be registered.
REQ-016 Stage 3 SHALL register the code as popcount(f), 0..48, and SHALL register a non-thermometer bit, set if any f[k]=0 with f[k+1]=1.
REQ-017 o_Code SHALL equal the stage-3 code, giving a latency of 3 cycles from i_TDC_code to o_Code.
REQ-018 The FSM SHALL have the states IDLE, FILL, ACC and DONE.
REQ-019 IDLE SHALL go to FILL when i_Start=1; on that transition the accumulator, the sample counter and the sticky flags SHALL be cleared.
REQ-020 FILL SHALL last exactly 3 cycles, flushing the pipeline, and SHALL then go to ACC.
REQ-021 ACC SHALL add the stage-3 code to the accumulator each cycle for exactly 2^AVG_LOG2 cycles, OR the overflow and error conditions into the sticky flags, and SHALL then go to DONE.
REQ-022 DONE SHALL load o_Sum and o_Avg, assert o_Valid for exactly that cycle, and go to IDLE on the next cycle.
REQ-023 i_Start SHALL be ignored in FILL, ACC and DONE, and no request SHALL be queued.
REQ-024 o_Sum, o_Avg, o_Overflow and o_Error SHALL hold their values from DONE until the next DONE; the sticky flags are cleared only at the start of a measurement.
REQ-025 The accumulator SHALL be 6+AVG_LOG2 bits wide and SHALL never wrap, since 48*2^N < 2^(6+N).
REQ-026 The minimum time from i_Start to o_Valid SHALL be 1+3+2^AVG_LOG2+1 cycles, measured from IDLE exit to DONE.

Reset
REQ-027 While i_RST_n=0, all pipeline registers, the accumulator, the counters and all outputs SHALL be 0, and the state SHALL be IDLE, asynchronously.
REQ-028 Reset asserted mid-measurement SHALL abort the measurement with no o_Valid pulse; after release, the block SHALL accept i_Start normally.
REQ-029 After reset release, o_Code SHALL show a valid decode only after 3 rising edges.

Verification (AVG_LOG2=2)
REQ-030 The bench SHALL check: i_TDC_code held at 48'h5555_5555_5555, then i_Start -> o_Code=0, o_Sum=0, o_Avg=0, flags 0, with o_Valid exactly 9 cycles after the i_Start cycle.
REQ-031 The bench SHALL check: i_TDC_code held at 48'h5555_555A_AAAA (20 ones) -> o_Code=20, o_Sum=80, o_Avg=20, o_Error=0.
REQ-032 The bench SHALL check: the REQ-031 code with normalised bit 10 cleared (single bubble) -> o_Code=20, o_Sum=80, o_Error=0.
REQ-033 The bench SHALL check: i_TDC_code held at 48'hAAAA_AAAA_AAAA -> o_Code=48, o_Sum=192, o_Avg=48, o_Overflow=1.
REQ-034 The bench SHALL check: normalised ones in bits 0-9 and 30-39 -> o_Code=20, o_Error=1; a following clean measurement SHALL clear o_Error to 0.
REQ-035 The bench SHALL check: i_Start pulsed during ACC -> ignored, with a single o_Valid; i_RST_n pulsed low in ACC -> all outputs 0, no o_Valid, and the next i_Start completes correctly.

Source files
------------

// File: rtl/tdc_48steps_decoder_if.sv
// Bus bundle for the 48-step TDC decoder: raw capture word and start request in, decoded results out.
`default_nettype none

interface tdc_48steps_decoder_if #(
  parameter int AVG_LOG2 = 2
);
  logic [47:0]           i_TDC_code;
  logic                  i_Start;
  logic                  o_Busy;
  logic [5:0]            o_Code;
  logic [5+AVG_LOG2:0]   o_Sum;
  logic [5:0]            o_Avg;
  logic                  o_Valid;
  logic                  o_Overflow;
  logic                  o_Error;

  modport master (
    output i_TDC_code, i_Start,
    input  o_Busy, o_Code, o_Sum, o_Avg, o_Valid, o_Overflow, o_Error
  );

  modport slave (
    input  i_TDC_code, i_Start,
    output o_Busy, o_Code, o_Sum, o_Avg, o_Valid, o_Overflow, o_Error
  );
endinterface

`default_nettype wire

// File: rtl/tdc_48steps_decoder.sv
// 48-cell TDC decoder: capture, polarity normalise + bubble filter, popcount, and 2^AVG_LOG2-sample averaging FSM.
`default_nettype none

module tdc_48steps_decoder #(
  parameter int AVG_LOG2 = 2
) (
  input  wire                          i_Clk_Ref,
  input  wire                          i_RST_n,
  tdc_48steps_decoder_if.slave         bus
);

  localparam int SUM_W = 6 + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 2;
  localparam logic [47:0]      POLARITY  = 48'h5555_5555_5555;
  localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(2);
  localparam logic [CNT_W-1:0] ACC_LAST  = CNT_W'((1 << AVG_LOG2) - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FILL = 2'd1;
  localparam logic [1:0] ACC  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [47:0]      s1;
  logic [47:0]      filt;
  logic [5:0]       code3;
  logic             bubble3;
  logic [49:0]      norm_ext;
  logic [47:0]      filt_nxt;
  logic [5:0]       popcnt;
  logic             non_thermo;
  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [SUM_W-1:0] acc;
  logic             ovf_sticky;
  logic             err_sticky;

  // Cells beyond the line: everything before cell 0 is "passed", nothing after cell 47 is.
  always_comb begin
    norm_ext = {1'b0, s1 ^ POLARITY, 1'b1};
    filt_nxt = '0;
    for (int k = 0; k < 48; k++) begin
      filt_nxt[k] = (norm_ext[k] & norm_ext[k+1]) | (norm_ext[k] & norm_ext[k+2]) |
                    (norm_ext[k+1] & norm_ext[k+2]);
    end
  end

  always_comb begin
    popcnt = '0;
    for (int k = 0; k < 48; k++) begin
      popcnt = popcnt + 6'(filt[k]);
    end
    non_thermo = |(~filt[46:0] & filt[47:1]);
  end

  always_ff @(posedge i_Clk_Ref or negedge i_RST_n) begin
    if (!i_RST_n) begin
      s1      <= '0;
      filt    <= '0;
      code3   <= '0;
      bubble3 <= 1'b0;
    end else begin
      s1      <= bus.i_TDC_code;
      filt    <= filt_nxt;
      code3   <= popcnt;
      bubble3 <= non_thermo;
    end
  end

  assign bus.o_Code = code3;

  always_ff @(posedge i_Clk_Ref or negedge i_RST_n) begin
    if (!i_RST_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.i_Start)      state_nxt = FILL;
      FILL:    if (cnt == FILL_LAST) state_nxt = ACC;
      ACC:     if (cnt == ACC_LAST)  state_nxt = DONE;
      default:                       state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.o_Busy = (state != IDLE);
  end

  // Results are registered out of DONE so o_Valid coincides with the new o_Sum/o_Avg.
  always_ff @(posedge i_Clk_Ref or negedge i_RST_n) begin
    if (!i_RST_n) begin
      cnt            <= '0;
      acc            <= '0;
      ovf_sticky     <= 1'b0;
      err_sticky     <= 1'b0;
      bus.o_Sum      <= '0;
      bus.o_Avg      <= '0;
      bus.o_Valid    <= 1'b0;
      bus.o_Overflow <= 1'b0;
      bus.o_Error    <= 1'b0;
    end else begin
      bus.o_Valid <= (state == DONE);
      case (state)
        IDLE: begin
          if (bus.i_Start) begin
            cnt        <= '0;
            acc        <= '0;
            ovf_sticky <= 1'b0;
            err_sticky <= 1'b0;
          end
        end
        FILL: begin
          cnt <= (cnt == FILL_LAST) ? '0 : cnt + 1'b1;
        end
        ACC: begin
          cnt        <= cnt + 1'b1;
          acc        <= acc + SUM_W'(code3);
          ovf_sticky <= ovf_sticky | (code3 == 6'd48);
          err_sticky <= err_sticky | bubble3;
        end
        default: begin
          bus.o_Sum      <= acc;
          bus.o_Avg      <= 6'(acc >> AVG_LOG2);
          bus.o_Overflow <= ovf_sticky;
          bus.o_Error    <= err_sticky;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tdc_48steps_decoder.sv
// Directed self-checking bench for tdc_48steps_decoder with AVG_LOG2=2.
`default_nettype none

module tb_tdc_48steps_decoder;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   vcnt   = 0;

  tdc_48steps_decoder_if #(.AVG_LOG2(2)) bus ();

  tdc_48steps_decoder #(.AVG_LOG2(2)) dut (
    .i_Clk_Ref (clk),
    .i_RST_n   (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bus.o_Valid) vcnt++;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run_meas(input string tag, input logic [47:0] raw, input int e_code,
                          input int e_sum, input int e_avg, input int e_ovf, input int e_err);
    int n;
    bit got;
    bus.i_TDC_code = raw;
    repeat (5) @(posedge clk);
    #1;
    check({tag, "_code"}, int'(bus.o_Code), e_code);
    bus.i_Start = 1'b1;
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(posedge clk);
      #1;
      bus.i_Start = 1'b0;
      n++;
      if (bus.o_Valid) got = 1'b1;
    end
    check({tag, "_latency"}, n, 9);
    check({tag, "_sum"}, int'(bus.o_Sum), e_sum);
    check({tag, "_avg"}, int'(bus.o_Avg), e_avg);
    check({tag, "_ovf"}, int'(bus.o_Overflow), e_ovf);
    check({tag, "_err"}, int'(bus.o_Error), e_err);
    @(posedge clk);
    #1;
    check({tag, "_valid_pulse"}, int'(bus.o_Valid), 0);
  endtask

  localparam logic [47:0] ZERO_RAW  = 48'h5555_5555_5555;
  localparam logic [47:0] TWENTY    = 48'h5555_555A_AAAA;
  localparam logic [47:0] FULL_RAW  = 48'hAAAA_AAAA_AAAA;
  localparam logic [47:0] SPLIT_RAW = 48'h00FF_C000_03FF ^ 48'h5555_5555_5555;

  initial begin
    int v0;
    rst_n          = 1'b0;
    bus.i_Start    = 1'b0;
    bus.i_TDC_code = ZERO_RAW;
    repeat (3) @(posedge clk);
    #1;
    check("rst_code", int'(bus.o_Code), 0);
    check("rst_sum", int'(bus.o_Sum), 0);
    check("rst_busy", int'(bus.o_Busy), 0);
    check("rst_valid", int'(bus.o_Valid), 0);
    rst_n = 1'b1;

    run_meas("zero", ZERO_RAW, 0, 0, 0, 0, 0);
    run_meas("twenty", TWENTY, 20, 80, 20, 0, 0);
    run_meas("bubble", TWENTY ^ (48'd1 << 10), 20, 80, 20, 0, 0);
    run_meas("full", FULL_RAW, 48, 192, 48, 1, 0);

    repeat (10) @(posedge clk);
    #1;
    check("hold_sum", int'(bus.o_Sum), 192);
    check("hold_ovf", int'(bus.o_Overflow), 1);

    run_meas("split", SPLIT_RAW, 20, 80, 20, 0, 1);
    run_meas("clean", TWENTY, 20, 80, 20, 0, 0);

    // Second start arrives mid-accumulation and must be dropped.
    bus.i_TDC_code = FULL_RAW;
    repeat (5) @(posedge clk);
    #1;
    v0 = vcnt;
    bus.i_Start = 1'b1;
    @(posedge clk);
    #1;
    bus.i_Start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("acc_busy", int'(bus.o_Busy), 1);
    bus.i_Start = 1'b1;
    @(posedge clk);
    #1;
    bus.i_Start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("ignore_start_valids", vcnt - v0, 1);
    check("ignore_start_idle", int'(bus.o_Busy), 0);
    check("ignore_start_sum", int'(bus.o_Sum), 192);

    // Reset in ACC aborts without a result.
    bus.i_TDC_code = TWENTY;
    repeat (5) @(posedge clk);
    #1;
    v0 = vcnt;
    bus.i_Start = 1'b1;
    @(posedge clk);
    #1;
    bus.i_Start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    check("abort_sum", int'(bus.o_Sum), 0);
    check("abort_avg", int'(bus.o_Avg), 0);
    check("abort_code", int'(bus.o_Code), 0);
    check("abort_ovf", int'(bus.o_Overflow), 0);
    check("abort_busy", int'(bus.o_Busy), 0);
    check("abort_valid", int'(bus.o_Valid), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("abort_no_valid", vcnt - v0, 0);
    check("abort_sum_held", int'(bus.o_Sum), 0);

    run_meas("after_rst", TWENTY, 20, 80, 20, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
